// File: rtl/systolic_output_deskew.sv
// Output de-skew for a systolic array: delays column j by LENGTH-1-j enabled cycles so a row
// leaves as one aligned vector, then tags and counts rows for a programmed capture.
module systolic_output_deskew #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LENGTH    = 256,
  parameter int unsigned ROW_CNT_W = 16
) (
  input  logic                             CLK,
  input  logic                             SYNC_RST_N,
  input  logic                             EN,
  input  logic                             Start,
  input  logic [ROW_CNT_W-1:0]             Expected_Rows,
  input  logic                             In_Valid,
  input  logic [LENGTH-1:0][WIDTH-1:0]     Inputs,
  output logic [LENGTH-1:0][WIDTH-1:0]     Outputs,
  output logic                             Out_Valid,
  output logic [ROW_CNT_W-1:0]             Row_Index,
  output logic                             Busy,
  output logic                             Done,
  output logic                             Overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [ROW_CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_CNT_W-1:0] idx_q, idx_d;
  logic                 ovf_q, ovf_d;
  logic                 aligned_v;
  logic                 out_valid;

  // Triangular delay line; the last column needs no delay.
  for (genvar j = 0; j < int'(LENGTH) - 1; j++) begin : g_col
    localparam int Depth = int'(LENGTH) - 1 - j;
    logic [Depth-1:0][WIDTH-1:0] dly_q;

    always_ff @(posedge CLK) begin
      if (!SYNC_RST_N) begin
        dly_q <= '0;
      end else if (EN) begin
        dly_q[0] <= Inputs[j];
        for (int k = 1; k < Depth; k++) begin
          dly_q[k] <= dly_q[k-1];
        end
      end
    end

    assign Outputs[j] = dly_q[Depth-1];
  end

  assign Outputs[LENGTH-1] = Inputs[LENGTH-1];

  // Valid travels with column 0, so it sees the longest delay.
  if (LENGTH > 1) begin : g_vpipe
    logic [LENGTH-2:0] vld_q;

    always_ff @(posedge CLK) begin
      if (!SYNC_RST_N) begin
        vld_q <= '0;
      end else if (EN) begin
        vld_q[0] <= In_Valid;
        for (int k = 1; k < int'(LENGTH) - 1; k++) begin
          vld_q[k] <= vld_q[k-1];
        end
      end
    end

    assign aligned_v = vld_q[LENGTH-2];
  end else begin : g_novpipe
    assign aligned_v = In_Valid;
  end

  always_ff @(posedge CLK) begin
    if (!SYNC_RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    out_valid = aligned_v & EN & (state_q == StRun);

    // A row landing outside a capture is dropped and flagged.
    if (aligned_v && EN && (state_q != StRun)) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Start is honoured even while stalled; a same-cycle stray row loses to it.
        if (Start && (Expected_Rows != '0)) begin
          state_d = StRun;
          cnt_d   = Expected_Rows;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StRun: begin
        if (out_valid) begin
          if (idx_q == cnt_q - ROW_CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + ROW_CNT_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign Out_Valid = out_valid;
  assign Row_Index = idx_q;
  assign Busy      = (state_q == StRun);
  assign Done      = (state_q == StDone);
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Bench for systolic_output_deskew: a history-queue model checked every cycle, plus directed
// scenarios with literal expectations, and a LENGTH=1 instance checked by hand.
module tb_systolic_output_deskew;
  localparam int L = 4;
  localparam int W = 8;
  localparam int R = 8;

  typedef logic [L-1:0][W-1:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0, en = 1'b1, start = 1'b0, in_v = 1'b0;
  logic [R-1:0] er = '0;
  vec_t         inp = '0, outp;
  logic         ov, busy, done, ovf;
  logic [R-1:0] ridx;

  logic              en1 = 1'b1, start1 = 1'b0, iv1 = 1'b0;
  logic [R-1:0]      er1 = '0;
  logic [0:0][W-1:0] in1 = '0, out1;
  logic              ov1, busy1, done1, ovf1;
  logic [R-1:0]      ridx1;

  systolic_output_deskew #(.WIDTH(W), .LENGTH(L), .ROW_CNT_W(R)) dut (
    .CLK(clk), .SYNC_RST_N(rst_n), .EN(en), .Start(start), .Expected_Rows(er),
    .In_Valid(in_v), .Inputs(inp), .Outputs(outp), .Out_Valid(ov), .Row_Index(ridx),
    .Busy(busy), .Done(done), .Overflow(ovf)
  );

  systolic_output_deskew #(.WIDTH(W), .LENGTH(1), .ROW_CNT_W(R)) dut1 (
    .CLK(clk), .SYNC_RST_N(rst_n), .EN(en1), .Start(start1), .Expected_Rows(er1),
    .In_Valid(iv1), .Inputs(in1), .Outputs(out1), .Out_Valid(ov1), .Row_Index(ridx1),
    .Busy(busy1), .Done(done1), .Overflow(ovf1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: the last L-1 enabled-edge samples of the inputs; the oldest entry is what column 0
  // shows now, entry j is what column j shows.
  vec_t samp_q[$];
  bit   vld_q[$];
  bit   m_run = 0, m_done = 0, m_ovf = 0, armed = 0;
  int   m_cnt = 0, m_idx = 0;

  initial forever begin
    bit av;
    bit ovv;
    @(posedge clk);
    if (!rst_n) begin
      samp_q.delete();
      vld_q.delete();
      for (int i = 0; i < L - 1; i++) begin
        samp_q.push_back('0);
        vld_q.push_back(1'b0);
      end
      m_run = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_idx = 0;
      armed = 1;
    end else if (armed) begin
      av  = vld_q[0];
      ovv = av && en && m_run;
      if (en) begin
        samp_q.push_back(inp);
        void'(samp_q.pop_front());
        vld_q.push_back(in_v);
        void'(vld_q.pop_front());
      end
      if (m_done) begin
        m_done = 0;
        m_idx  = 0;
        if (av && en) m_ovf = 1;
      end else if (m_run) begin
        if (ovv) begin
          if (m_idx == m_cnt - 1) begin
            m_run  = 0;
            m_done = 1;
          end else begin
            m_idx++;
          end
        end
      end else begin
        if (av && en) m_ovf = 1;
        if (start && er != 0) begin
          m_run = 1; m_cnt = int'(er); m_idx = 0; m_ovf = 0;
        end
      end
    end
  end

  // Per-scenario logs indexed by scenario cycle.
  int   tc = 0;
  bit   ov_log[64], done_log[64], busy_log[64], ovf_log[64];
  vec_t out_log[64];
  vec_t row_log[$];
  int   idx_log[$];

  initial forever begin
    vec_t exp_out;
    bit   exp_ov;
    @(negedge clk);
    if (armed) begin
      for (int j = 0; j < L - 1; j++) exp_out[j] = samp_q[j][j];
      exp_out[L-1] = inp[L-1];
      exp_ov = vld_q[0] && en && m_run;
      chk("outputs", outp, exp_out);
      chk("out_valid", ov, exp_ov);
      chk("row_index", ridx, m_idx);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("overflow", ovf, m_ovf);
      if (tc >= 0 && tc < 64) begin
        ov_log[tc] = ov; done_log[tc] = done; busy_log[tc] = busy; ovf_log[tc] = ovf;
        out_log[tc] = outp;
      end
      if (ov === 1'b1) begin
        row_log.push_back(outp);
        idx_log.push_back(int'(ridx));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tc++;
  endtask

  task automatic clear_logs();
    tc = 0;
    for (int i = 0; i < 64; i++) begin
      ov_log[i] = 0; done_log[i] = 0; busy_log[i] = 0; ovf_log[i] = 0; out_log[i] = '0;
    end
    row_log.delete();
    idx_log.delete();
  endtask

  function automatic int count1(input bit a[64]);
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(a[i]);
    return n;
  endfunction

  function automatic vec_t row_at(input int i);
    return (i < row_log.size()) ? row_log[i] : 'x;
  endfunction

  function automatic vec_t row_exp(input int r);
    vec_t v;
    for (int j = 0; j < L; j++) v[j] = W'(16 * r + j);
    return v;
  endfunction

  // Skewed feeder: row r column j appears at active cycle r+j; inputs hold while stalled.
  task automatic feed(input int nrows, input int st_at, input int st_er, input int st2_at,
                      input int st2_er, input int stall_a, input int stall_b, input int rst_at);
    int a = 0;
    int c = 0;
    int r;
    clear_logs();
    while (a < nrows + L + 2) begin
      start = (c == st_at) || (c == st2_at);
      er    = (c == st2_at) ? R'(st2_er) : R'(st_er);
      en    = !((c == stall_a) || (c == stall_b));
      in_v  = (a < nrows);
      for (int j = 0; j < L; j++) begin
        r = a - j;
        inp[j] = (r >= 0 && r < nrows) ? W'(16 * r + j) : '0;
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        break;
      end
      tick();
      if (en) a++;
      c++;
    end
    start = 1'b0; en = 1'b1; in_v = 1'b0; inp = '0; er = '0;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic three-row capture.
    feed(3, 0, 3, -1, 0, -1, -1, -1);
    chk("t1_ov_c2", ov_log[2], 0);
    chk("t1_ov_c3", ov_log[3], 1);
    chk("t1_ov_c4", ov_log[4], 1);
    chk("t1_ov_c5", ov_log[5], 1);
    chk("t1_ov_cnt", count1(ov_log), 3);
    chk("t1_row0_lit", row_at(0), 32'h03020100);
    chk("t1_row2_lit", row_at(2), 32'h23222120);
    for (int i = 0; i < 3; i++) begin
      chk("t1_row", row_at(i), row_exp(i));
      chk("t1_idx", (i < idx_log.size()) ? idx_log[i] : -1, i);
    end
    chk("t1_done_c6", done_log[6], 1);
    chk("t1_done_cnt", count1(done_log), 1);
    chk("t1_busy_c7", busy_log[7], 0);

    // Same capture with stalls: rows unchanged, no loss or duplication.
    feed(3, 0, 3, -1, 0, 2, 4, -1);
    chk("t2_ov_c4", ov_log[4], 0);
    chk("t2_ov_c5", ov_log[5], 1);
    chk("t2_ov_cnt", count1(ov_log), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_row", row_at(i), row_exp(i));
      chk("t2_idx", (i < idx_log.size()) ? idx_log[i] : -1, i);
    end
    chk("t2_done_cnt", count1(done_log), 1);

    // Stray row while idle, then a Start clears the flag.
    feed(1, -1, 0, -1, 0, -1, -1, -1);
    chk("t3_ov_cnt", count1(ov_log), 0);
    chk("t3_ovf_c3", ovf_log[3], 0);
    chk("t3_ovf_c4", ovf_log[4], 1);
    feed(1, 0, 1, -1, 0, -1, -1, -1);
    chk("t3_ovf_held", ovf_log[0], 1);
    chk("t3_ovf_clr", ovf_log[1], 0);
    chk("t3_done_cnt", count1(done_log), 1);

    // Zero-row Start ignored; Start during RUN does not relatch the count.
    clear_logs();
    start = 1'b1; er = '0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t4_busy_c1", busy_log[1], 0);
    chk("t4_done_zero", count1(done_log), 0);
    feed(2, 0, 2, 1, 5, -1, -1, -1);
    chk("t4_ov_cnt", count1(ov_log), 2);
    chk("t4_done_c5", done_log[5], 1);
    chk("t4_done_cnt", count1(done_log), 1);

    // Reset after the first of three rows aborts silently.
    feed(3, 0, 3, -1, 0, -1, -1, 3);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_ov_cnt", count1(ov_log), 1);
    chk("t5_out_c4", out_log[4], 0);
    chk("t5_busy_c4", busy_log[4], 0);
    chk("t5_ovf_c4", ovf_log[4], 0);
    chk("t5_done_cnt", count1(done_log), 0);
    feed(3, 0, 3, -1, 0, -1, -1, -1);
    chk("t5b_ov_cnt", count1(ov_log), 3);
    chk("t5b_row2", row_at(2), row_exp(2));
    chk("t5b_done_cnt", count1(done_log), 1);

    // LENGTH=1: no delay, valid passes straight through during RUN.
    start1 = 1'b1; er1 = 8'd2;
    #1 chk("l1_busy_pre", busy1, 0);
    tick();
    start1 = 1'b0; iv1 = 1'b1; en1 = 1'b0; in1 = 8'h11;
    #1 chk("l1_stall_ov", ov1, 0);
    chk("l1_busy", busy1, 1);
    tick();
    en1 = 1'b1; in1 = 8'hA5;
    #1 chk("l1_ov0", ov1, 1);
    chk("l1_out0", out1, 8'hA5);
    chk("l1_idx0", ridx1, 0);
    tick();
    in1 = 8'h5A;
    #1 chk("l1_ov1", ov1, 1);
    chk("l1_out1", out1, 8'h5A);
    chk("l1_idx1", ridx1, 1);
    tick();
    iv1 = 1'b0;
    #1 chk("l1_done", done1, 1);
    chk("l1_busy_done", busy1, 0);
    tick();
    #1 chk("l1_done_end", done1, 0);
    chk("l1_ovf", ovf1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
